// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the load/store access unit: funct3 sizes,
// ram write-enable codes and the controller state enum.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    SPLIT,
    RESP
  } state_t;

  // Access size in bytes; illegal encodings fall to 4 so range checks stay conservative.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return 3'd1;
      F3_H, F3_HU: return 3'd2;
      default:     return 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] f3, input logic write);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !write;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lsb);
    case (f3)
      F3_W:        return lsb == 2'b00;
      F3_H, F3_HU: return !lsb[0];
      default:     return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] store_we(input logic [2:0] f3);
    case (f3)
      F3_W:    return WE_WORD;
      F3_H:    return WE_HALF;
      default: return WE_BYTE;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_W:    return wdata;
      F3_H:    return {16'h0, wdata[15:0]};
      default: return {24'h0, wdata[7:0]};
    endcase
  endfunction

  // Byte k of an n-byte store value, counted from its most significant byte.
  function automatic logic [7:0] split_byte(input logic [31:0] wdata, input logic [2:0] n,
                                            input logic [1:0] k);
    logic [2:0]  pos;
    logic [31:0] shifted;
    pos     = n - {1'b0, k} - 3'd1;
    shifted = wdata >> {pos, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/load_format.sv
// Sign/zero extension of big-endian load data; the value sits left-justified in raw.
module load_format
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[31]}}, raw[31:24]};
      F3_BU:   result = {24'h0, raw[31:24]};
      F3_H:    result = {{16{raw[31]}}, raw[31:16]};
      F3_HU:   result = {16'h0, raw[31:16]};
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the byte-addressed data ram: aligned accesses in one
// ram cycle, misaligned ones as a sequence of single-byte accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_SIZE = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [2:0]  mem_write_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state;
  logic        r_write;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  k;
  logic [23:0] asm_q;

  logic [2:0]  req_n;
  logic [32:0] req_last;
  logic        req_fault;
  logic [2:0]  n;
  logic        last_k;
  logic [31:0] asm_next;
  logic [31:0] fmt_raw;
  logic [31:0] fmt_data;

  assign req_ready = (state == IDLE) && !reset;

  // Last byte computed in 33 bits so addresses near 2^32 cannot wrap into range.
  assign req_n     = access_size(req_funct3);
  assign req_last  = {1'b0, req_addr} + {30'h0, req_n} - 33'd1;
  assign req_fault = !funct3_legal(req_funct3, req_write) || (req_last > 33'(MEM_SIZE - 1));

  assign n        = access_size(r_f3);
  assign last_k   = ({1'b0, k} == (n - 3'd1));
  assign asm_next = {asm_q, mem_rdata[31:24]};

  // Split loads re-left-justify the assembled bytes so one formatter serves both paths.
  always_comb begin
    fmt_raw = mem_rdata;
    if (state == SPLIT) begin
      case (n)
        3'd4:    fmt_raw = asm_next;
        3'd2:    fmt_raw = {asm_next[15:0], 16'h0};
        default: fmt_raw = {asm_next[7:0], 24'h0};
      endcase
    end
  end

  load_format u_load_format (
    .funct3 (r_f3),
    .raw    (fmt_raw),
    .result (fmt_data)
  );

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      r_write          <= 1'b0;
      r_f3             <= F3_B;
      r_addr           <= '0;
      r_wdata          <= '0;
      k                <= '0;
      asm_q            <= '0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_fault       <= 1'b0;
      mem_write_enable <= WE_NONE;
      mem_addr         <= '0;
      mem_wdata        <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            k       <= '0;
            asm_q   <= '0;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_fault <= 1'b1;
            end else if (is_aligned(req_funct3, req_addr[1:0])) begin
              state            <= ACCESS;
              mem_addr         <= req_addr;
              mem_write_enable <= req_write ? store_we(req_funct3) : WE_NONE;
              mem_wdata        <= req_write ? store_mask(req_funct3, req_wdata) : '0;
            end else begin
              state            <= SPLIT;
              mem_addr         <= req_addr;
              mem_write_enable <= req_write ? WE_BYTE : WE_NONE;
              mem_wdata        <= req_write ? {24'h0, split_byte(req_wdata, req_n, 2'd0)} : '0;
            end
          end
        end
        ACCESS: begin
          state            <= RESP;
          resp_valid       <= 1'b1;
          resp_fault       <= 1'b0;
          resp_rdata       <= r_write ? '0 : fmt_data;
          mem_write_enable <= WE_NONE;
          mem_addr         <= '0;
          mem_wdata        <= '0;
        end
        SPLIT: begin
          asm_q <= asm_next[23:0];
          if (last_k) begin
            state            <= RESP;
            resp_valid       <= 1'b1;
            resp_fault       <= 1'b0;
            resp_rdata       <= r_write ? '0 : fmt_data;
            mem_write_enable <= WE_NONE;
            mem_addr         <= '0;
            mem_wdata        <= '0;
          end else begin
            k         <= k + 2'd1;
            mem_addr  <= mem_addr + 32'd1;
            mem_wdata <= r_write ? {24'h0, split_byte(r_wdata, n, k + 2'd1)} : '0;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
